// File: rtl/i2c_rx_byte.sv
// i2c_rx_byte: receive-side byte assembler for an I2C slave.
// Consumes SCL edge strobes and synchronized SCL/SDA levels, detects START/STOP,
// shifts bits in MSB-first, presents each completed byte and flags the ACK bit window.
// Optional feature: define I2C_ADDR_MATCH_EN to treat the first byte after each START
// as an address byte compared against SLAVE_ADDR (only meaningful with BITS == 8).
module i2c_rx_byte #(
  parameter int         BITS       = 8,
  parameter logic [6:0] SLAVE_ADDR = 7'h1E
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            scl_in,
  input  logic            sda_in,
  input  logic            rising_edge_found,
  input  logic            falling_edge_found,
  output logic            start_found,
  output logic            stop_found,
  output logic [BITS-1:0] rx_data,
  output logic            byte_received,
  output logic            ack_window,
  output logic            busy,
  output logic            addr_match,
  output logic            rw_bit
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RX_BITS,
    WAIT_ACK,
    ACK_BIT
  } state_t;

  state_t          state;
  logic [CW-1:0]   bit_cnt;
  logic [BITS-1:0] shift_reg;
  logic [BITS-1:0] shift_next;
  logic            sda_prev;
  logic            start_det;
  logic            stop_det;
  logic            last_bit;
  logic            ack_seen;

`ifdef I2C_ADDR_MATCH_EN
  logic            first_byte;
`else
  logic            unused_cfg;
  assign unused_cfg = ^SLAVE_ADDR;
  assign addr_match = 1'b0;
  assign rw_bit     = 1'b0;
`endif

  // Bus condition decode and next shift value from the current SDA sample
  always_comb begin
    start_det  = scl_in & sda_prev & ~sda_in;
    stop_det   = scl_in & ~sda_prev & sda_in;
    shift_next = {shift_reg[BITS-2:0], sda_in};
    last_bit   = (bit_cnt == CW'(BITS - 1));
  end

  // Previous SDA sample, idles high so a bus already at rest never looks like a START
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sda_prev <= 1'b1;
    else        sda_prev <= sda_in;
  end

  // Byte FSM: START/STOP take priority over any SCL edge seen in the same cycle
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      rx_data       <= '0;
      start_found   <= 1'b0;
      stop_found    <= 1'b0;
      byte_received <= 1'b0;
      ack_window    <= 1'b0;
      busy          <= 1'b0;
      ack_seen      <= 1'b0;
`ifdef I2C_ADDR_MATCH_EN
      first_byte    <= 1'b0;
      addr_match    <= 1'b0;
      rw_bit        <= 1'b0;
`endif
    end else begin
      start_found   <= start_det;
      stop_found    <= stop_det;
      byte_received <= 1'b0;
`ifdef I2C_ADDR_MATCH_EN
      addr_match    <= 1'b0;
`endif
      if (start_det) begin
        state      <= RX_BITS;
        bit_cnt    <= '0;
        shift_reg  <= '0;
        ack_window <= 1'b0;
        ack_seen   <= 1'b0;
        busy       <= 1'b1;
`ifdef I2C_ADDR_MATCH_EN
        first_byte <= 1'b1;
`endif
      end else if (stop_det && state != IDLE) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        shift_reg  <= '0;
        ack_window <= 1'b0;
        ack_seen   <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          RX_BITS: begin
            if (rising_edge_found) begin
              shift_reg <= shift_next;
              bit_cnt   <= bit_cnt + 1'b1;
              if (last_bit) begin
`ifdef I2C_ADDR_MATCH_EN
                if (first_byte) begin
                  first_byte <= 1'b0;
                  if (shift_next[BITS-1:BITS-7] == SLAVE_ADDR) begin
                    addr_match <= 1'b1;
                    rw_bit     <= shift_next[0];
                    state      <= WAIT_ACK;
                  end else begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                  end
                end else begin
                  rx_data       <= shift_next;
                  byte_received <= 1'b1;
                  state         <= WAIT_ACK;
                end
`else
                rx_data       <= shift_next;
                byte_received <= 1'b1;
                state         <= WAIT_ACK;
`endif
              end
            end
          end
          WAIT_ACK: begin
            if (falling_edge_found) begin
              ack_window <= 1'b1;
              ack_seen   <= 1'b0;
              state      <= ACK_BIT;
            end
          end
          ACK_BIT: begin
            if (rising_edge_found) begin
              ack_seen <= 1'b1;
            end else if (falling_edge_found && ack_seen) begin
              ack_window <= 1'b0;
              ack_seen   <= 1'b0;
              bit_cnt    <= '0;
              shift_reg  <= '0;
              state      <= RX_BITS;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
